sad_search_ctrl: RTL and testbench

//  Full-search scheduler for the SAD motion-estimation datapath. On start, sweeps every

---
 rtl/sad_pkg.sv | 18 +
 rtl/sad_mv_counter.sv | 62 ++++++
 rtl/sad_search_ctrl.sv | 147 ++++++++++++++
 tb/tb_sad_search_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared types, defaults and helpers for the full-search SAD motion-estimation scheduler.
package sad_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int BLK_DEF   = 4;
  localparam int RANGE_DEF = 2;
  localparam int SAD_W_DEF = 12;
  localparam int ACC_W_DEF = 16;
  localparam int MV_W_DEF  = 4;

  typedef logic signed [MV_W_DEF-1:0] mv_t;

  function automatic int NUM_CAND(input int range);
    return (2 * range + 1) * (2 * range + 1);
  endfunction

endpackage

// File: rtl/sad_mv_counter.sv
// Raster (mvy outer, mvx, row inner) walker over the search window; clr loads the first
// candidate, en advances one row and wraps back to the first candidate after the last.
module sad_mv_counter
  import sad_pkg::*;
#(
  parameter int BLK   = BLK_DEF,
  parameter int RANGE = RANGE_DEF,
  parameter int MV_W  = MV_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   en_i,
  output logic [MV_W-1:0]        mvx_o,
  output logic [MV_W-1:0]        mvy_o,
  output logic [$clog2(BLK)-1:0] row_o,
  output logic                   row_last_o,
  output logic                   cand_last_o
);

  localparam int              ROW_W   = $clog2(BLK);
  localparam logic [MV_W-1:0] MV_MAX  = MV_W'(RANGE);
  localparam logic [MV_W-1:0] MV_MIN  = MV_W'(-RANGE);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(BLK - 1);

  logic [MV_W-1:0]  mvx_q;
  logic [MV_W-1:0]  mvy_q;
  logic [ROW_W-1:0] row_q;
  logic             x_last;
  logic             y_last;

  assign x_last      = (mvx_q == MV_MAX);
  assign y_last      = (mvy_q == MV_MAX);
  assign row_last_o  = (row_q == ROW_MAX);
  assign cand_last_o = x_last & y_last;
  assign mvx_o       = mvx_q;
  assign mvy_o       = mvy_q;
  assign row_o       = row_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mvx_q <= '0;
      mvy_q <= '0;
      row_q <= '0;
    end else if (clr_i) begin
      mvx_q <= MV_MIN;
      mvy_q <= MV_MIN;
      row_q <= '0;
    end else if (en_i) begin
      if (!row_last_o) begin
        row_q <= row_q + ROW_W'(1);
      end else begin
        row_q <= '0;
        mvx_q <= x_last ? MV_MIN : mvx_q + MV_W'(1);
        if (x_last) begin
          mvy_q <= y_last ? MV_MIN : mvy_q + MV_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/sad_search_ctrl.sv
// Full-search SAD scheduler: issues one row request per (mv, row), sums returned row SADs
// per candidate with saturation and keeps the earliest strictly-smallest candidate.
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int BLK   = BLK_DEF,
  parameter int RANGE = RANGE_DEF,
  parameter int SAD_W = SAD_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int MV_W  = MV_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [MV_W-1:0]        req_mvx,
  output logic [MV_W-1:0]        req_mvy,
  output logic [$clog2(BLK)-1:0] req_row,
  input  logic                   rsp_valid,
  input  logic [SAD_W-1:0]       rsp_sad,
  output logic                   done,
  output logic [ACC_W-1:0]       best_sad,
  output logic [MV_W-1:0]        best_mvx,
  output logic [MV_W-1:0]        best_mvy
);

  state_t            state_q;
  logic              busy_q;
  logic              req_valid_q;
  logic              done_q;
  logic              first_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [ACC_W:0]    sum_wide;
  logic [ACC_W-1:0]  best_sad_q;
  logic [MV_W-1:0]   best_mvx_q;
  logic [MV_W-1:0]   best_mvy_q;

  logic              start_acc;
  logic              iss_en;
  logic              col_en;
  logic              iss_row_last;
  logic              iss_cand_last;
  logic [MV_W-1:0]   col_mvx;
  logic [MV_W-1:0]   col_mvy;
  logic [$clog2(BLK)-1:0] col_row;
  logic              col_row_last;
  logic              col_cand_last;

  assign start_acc = (state_q == IDLE) && start;
  assign iss_en    = (state_q == RUN) && req_valid_q && req_ready;
  assign col_en    = (state_q == RUN) && rsp_valid;

  sad_mv_counter #(.BLK(BLK), .RANGE(RANGE), .MV_W(MV_W)) u_issue (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (start_acc),
    .en_i       (iss_en),
    .mvx_o      (req_mvx),
    .mvy_o      (req_mvy),
    .row_o      (req_row),
    .row_last_o (iss_row_last),
    .cand_last_o(iss_cand_last)
  );

  // Collect side walks the same raster on responses so it never depends on issue progress.
  sad_mv_counter #(.BLK(BLK), .RANGE(RANGE), .MV_W(MV_W)) u_collect (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (start_acc),
    .en_i       (col_en),
    .mvx_o      (col_mvx),
    .mvy_o      (col_mvy),
    .row_o      (col_row),
    .row_last_o (col_row_last),
    .cand_last_o(col_cand_last)
  );

  always_comb begin
    sum_wide = {1'b0, acc_q} + (ACC_W+1)'(rsp_sad);
    acc_d    = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      req_valid_q <= 1'b0;
      done_q      <= 1'b0;
      first_q     <= 1'b0;
      acc_q       <= '0;
      best_sad_q  <= {ACC_W{1'b1}};
      best_mvx_q  <= '0;
      best_mvy_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            req_valid_q <= 1'b1;
            first_q     <= 1'b1;
            acc_q       <= '0;
          end
        end
        RUN: begin
          if (iss_en && iss_row_last && iss_cand_last) begin
            req_valid_q <= 1'b0;
          end
          if (col_en) begin
            if (col_row_last) begin
              acc_q   <= '0;
              first_q <= 1'b0;
              if (first_q || (acc_d < best_sad_q)) begin
                best_sad_q <= acc_d;
                best_mvx_q <= col_mvx;
                best_mvy_q <= col_mvy;
              end
              if (col_cand_last) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              acc_q <= acc_d;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign req_valid = req_valid_q;
  assign done      = done_q;
  assign best_sad  = best_sad_q;
  assign best_mvx  = best_mvx_q;
  assign best_mvy  = best_mvy_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Scoreboard bench: a default instance and a narrow-accumulator instance share one datapath model.
module tb_sad_search_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        req_ready;
  logic        rsp_valid;
  logic [11:0] rsp_sad;

  logic        busy, req_valid, done;
  logic [3:0]  req_mvx, req_mvy, best_mvx, best_mvy;
  logic [1:0]  req_row;
  logic [15:0] best_sad;

  logic        s_busy, s_req_valid, s_done;
  logic [3:0]  s_req_mvx, s_req_mvy, s_best_mvx, s_best_mvy;
  logic [1:0]  s_req_row;
  logic [12:0] s_best_sad;

  sad_search_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mvx(req_mvx), .req_mvy(req_mvy), .req_row(req_row),
    .rsp_valid(rsp_valid), .rsp_sad(rsp_sad), .done(done),
    .best_sad(best_sad), .best_mvx(best_mvx), .best_mvy(best_mvy)
  );

  sad_search_ctrl #(.ACC_W(13)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(s_busy),
    .req_valid(s_req_valid), .req_ready(req_ready),
    .req_mvx(s_req_mvx), .req_mvy(s_req_mvy), .req_row(s_req_row),
    .rsp_valid(rsp_valid), .rsp_sad(rsp_sad), .done(s_done),
    .best_sad(s_best_sad), .best_mvx(s_best_mvx), .best_mvy(s_best_mvy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int sad;
    int sad_s;
    int mvx;
    int mvy;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int          due;
    logic [11:0] sad;
  } rsp_t;
  rsp_t pend[$];

  int mode = 1;
  int ready_mode = 0;
  int req_cnt = 0;
  int inject = 0;
  int done_seen = 0;
  int edge_n = 0;
  int last_due = 0;
  bit stall_q = 0;
  logic [10:0] stall_vec;

  function automatic logic [11:0] sad_of(input int md, input int x, input int y);
    if (md == 1) return (x == 1 && y == -1) ? 12'd1 : 12'd10;
    if (md == 2) return 12'd7;
    return 12'd4095;
  endfunction

  // Datapath model: drives req_ready/rsp_* for the next rising edge, checks raster order and stall hold.
  always @(negedge clk) begin
    int   ex, ey, er, lat, due;
    rsp_t r;
    edge_n++;
    if (!rst_n) begin
      pend.delete();
      last_due  = 0;
      stall_q   = 0;
      rsp_valid = 1'b0;
    end else begin
      if (stall_q)
        chk("stall_hold", {req_valid, req_mvx, req_mvy, req_row}, stall_vec);
      req_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      stall_q   = req_valid && !req_ready;
      stall_vec = {req_valid, req_mvx, req_mvy, req_row};
      if (req_valid && req_ready) begin
        er = req_cnt % 4;
        ex = (req_cnt / 4) % 5 - 2;
        ey = req_cnt / 20 - 2;
        chk("req_order", {req_mvx, req_mvy, req_row},
            {4'(ex), 4'(ey), 2'(er)});
        chk("req_order_sat", {s_req_valid, s_req_mvx, s_req_mvy, s_req_row},
            {1'b1, 4'(ex), 4'(ey), 2'(er)});
        lat = (ready_mode != 0) ? 1 + (req_cnt % 6) : 3;
        due = (edge_n + lat > last_due) ? edge_n + lat : last_due + 1;
        r.due = due;
        r.sad = sad_of(mode, ex, ey);
        pend.push_back(r);
        last_due = due;
        req_cnt++;
      end
      if (pend.size() > 0 && pend[0].due <= edge_n) begin
        rsp_valid = 1'b1;
        rsp_sad   = pend[0].sad;
        void'(pend.pop_front());
      end else if (inject > 0) begin
        rsp_valid = 1'b1;
        rsp_sad   = 12'd1;
        inject--;
      end else begin
        rsp_valid = 1'b0;
      end
    end
  end

  // Monitor: every done pulse pops one expectation.
  bit prev_done = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (prev_done) chk("done_one_cycle", done, 0);
      prev_done = done;
      if (done || s_done) begin
        done_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("best_sad", best_sad, e.sad);
          chk("best_mvx", $signed(best_mvx), e.mvx);
          chk("best_mvy", $signed(best_mvy), e.mvy);
          chk("sat_best_sad", s_best_sad, e.sad_s);
          chk("sat_best_mv", {s_best_mvx, s_best_mvy}, {4'(e.mvx), 4'(e.mvy)});
          chk("done_both", {done, s_done, busy, s_busy}, 4'b1100);
        end
      end
    end else begin
      prev_done = 0;
    end
  end

  task automatic run_search(input int md, input int rdy, input int pulse_at,
                            input int e_sad, input int e_sad_s, input int e_x, input int e_y);
    exp_t e;
    int   d0;
    e.sad = e_sad; e.sad_s = e_sad_s; e.mvx = e_x; e.mvy = e_y;
    exp_q.push_back(e);
    mode = md;
    ready_mode = rdy;
    req_cnt = 0;
    d0 = done_seen;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3000 && done_seen == d0; i++) begin
      @(negedge clk);
      start = (i == pulse_at);
    end
    start = 1'b0;
    chk("done_seen", done_seen - d0, 1);
    chk("req_count", req_cnt, sad_pkg::NUM_CAND(2) * 4);
    repeat (4) @(negedge clk);
    chk("single_done", done_seen - d0, 1);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; req_ready = 1'b1; rsp_valid = 1'b0; rsp_sad = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, req_valid, done}, 0);
    chk("rst_req", {req_mvx, req_mvy, req_row}, 0);
    chk("rst_best_sad", best_sad, 16'hFFFF);
    chk("rst_best_mv", {best_mvx, best_mvy}, 0);
    chk("rst_sat_best", s_best_sad, 13'h1FFF);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_search(1, 0, -1, 4, 4, 1, -1);
    run_search(2, 0, -1, 28, 28, -2, -2);
    run_search(1, 1, -1, 4, 4, 1, -1);
    run_search(4, 0, -1, 16380, 8191, -2, -2);

    // Abort mid-search with reset; no done may follow.
    mode = 1; ready_mode = 0; req_cnt = 0; d0 = done_seen;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 500 && req_cnt < 40; i++) @(negedge clk);
    chk("reached_40", req_cnt >= 40, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_ctrl", {busy, req_valid, done, s_busy, s_req_valid, s_done}, 0);
    chk("abort_req", {req_mvx, req_mvy, req_row}, 0);
    chk("abort_best_sad", best_sad, 16'hFFFF);
    chk("abort_best_mv", {best_mvx, best_mvy}, 0);
    chk("abort_sat_best", s_best_sad, 13'h1FFF);
    @(negedge clk); rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_seen - d0, 0);
    run_search(1, 0, -1, 4, 4, 1, -1);

    // start during RUN, then stray responses in IDLE.
    run_search(1, 0, 30, 4, 4, 1, -1);
    d0 = done_seen;
    inject = 3;
    repeat (6) @(negedge clk);
    chk("idle_rsp_no_done", done_seen - d0, 0);
    chk("idle_rsp_busy", {busy, req_valid}, 0);
    run_search(2, 0, -1, 28, 28, -2, -2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
